filter_ch_scheduler: RTL and testbench

- Time-multiplexes one shared filter datapath (FIR or IIR, N-bit sample in/out, single-cycle `en` strobe) between NCH sample channels.
- Round-robin arbitrates channel requests and latches the winning sample.
- Sequences the datapath `en` strobe, waits the datapath latency, then captures and tags the result.
- The datapath holds per-channel delay-line context banks indexed by `flt_ch`; this block only drives the index.

---
 rtl/filter_ch_scheduler.sv | 142 ++++++++++++++
 tb/tb_filter_ch_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_ch_scheduler.sv
// Round-robin scheduler that time-multiplexes one shared filter datapath
// between NCH sample channels and tags each captured result with its channel.
module filter_ch_scheduler #(
    parameter int N   = 16,
    parameter int NCH = 4,
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req,
    input  logic [NCH*N-1:0]   x_in,
    input  logic [NCH-1:0]     ch_mask,
    output logic [NCH-1:0]     ack,
    output logic               flt_en,
    output logic [N-1:0]       flt_x,
    output logic [3:0]         flt_ch,
    input  logic [N-1:0]       flt_y,
    output logic [N-1:0]       y_out,
    output logic [3:0]         y_ch,
    output logic               y_valid,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     last_q, last_d;
    logic [3:0]     ch_q, ch_d;
    logic [N-1:0]   x_q, x_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic           en_q, en_d;
    logic [N-1:0]   y_q, y_d;
    logic [3:0]     ych_q, ych_d;
    logic           yv_q, yv_d;

    logic [15:0]    elig;
    logic [4:0]     cand;
    logic           found;
    logic [3:0]     grant;
    logic [N-1:0]   grant_x;

    assign elig = 16'(req & ch_mask);

    // Search upward from the channel after the last one served, wrapping at NCH.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = 5'(last_q) + 5'(i);
            if (cand >= 5'(NCH)) cand = cand - 5'(NCH);
            if (!found && elig[cand[3:0]]) begin
                found = 1'b1;
                grant = cand[3:0];
            end
        end
    end

    always_comb begin
        grant_x = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == 4'(i)) grant_x = x_in[i*N +: N];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ch_d    = ch_q;
        x_d     = x_q;
        ack_d   = '0;
        en_d    = 1'b0;
        y_d     = y_q;
        ych_d   = ych_q;
        yv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ch_d    = grant;
                    x_d     = grant_x;
                    ack_d   = {{(NCH-1){1'b0}}, 1'b1} << grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                en_d    = 1'b1;
                cnt_d   = 4'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = CAPTURE;
            end
            CAPTURE: begin
                y_d     = flt_y;
                ych_d   = ch_q;
                yv_d    = 1'b1;
                last_d  = ch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to NCH-1 so channel 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 4'(NCH - 1);
            ch_q    <= '0;
            x_q     <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            y_q     <= '0;
            ych_q   <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            y_q     <= y_d;
            ych_q   <= ych_d;
            yv_q    <= yv_d;
        end
    end

    assign ack     = ack_q;
    assign flt_en  = en_q;
    assign flt_x   = x_q;
    assign flt_ch  = ch_q;
    assign y_out   = y_q;
    assign y_ch    = ych_q;
    assign y_valid = yv_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_filter_ch_scheduler.sv
// Bench for filter_ch_scheduler: three instances (LAT = 2, 1, 15) share stimulus
// and are compared every cycle against a transaction-timing reference model.
module tb_filter_ch_scheduler;
    localparam int N   = 16;
    localparam int NCH = 4;
    localparam int ND  = 3;
    localparam int OW  = NCH + 1 + N + 4 + N + 4 + 1 + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NCH-1:0]     req_r [ND];
    logic [NCH*N-1:0]   x_r;
    logic [NCH-1:0]     mask_r;
    logic [NCH-1:0]     ack_w [ND];
    logic               en_w [ND];
    logic [N-1:0]       fx_w [ND];
    logic [3:0]         fch_w [ND];
    logic [N-1:0]       fy_w [ND];
    logic [N-1:0]       yo_w [ND];
    logic [3:0]         ych_w [ND];
    logic               yv_w [ND];
    logic               busy_w [ND];
    logic [N-1:0]       pipe [ND][16];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int             m_idle [ND];
    int             m_ack [ND];
    int             m_en [ND];
    int             m_yv [ND];
    int             m_last [ND];
    logic [3:0]     m_ch [ND];
    logic [3:0]     m_pch [ND];
    logic [3:0]     m_ych [ND];
    logic [N-1:0]   m_x [ND];
    logic [N-1:0]   m_py [ND];
    logic [N-1:0]   m_yout [ND];
    logic [NCH-1:0] pend [ND];
    bit             hold = 1'b0;

    always #5 clk = ~clk;

    filter_ch_scheduler #(.N(N), .NCH(NCH), .LAT(2)) dut0 (
        .clk(clk), .rst(rst), .req(req_r[0]), .x_in(x_r), .ch_mask(mask_r),
        .ack(ack_w[0]), .flt_en(en_w[0]), .flt_x(fx_w[0]), .flt_ch(fch_w[0]),
        .flt_y(fy_w[0]), .y_out(yo_w[0]), .y_ch(ych_w[0]), .y_valid(yv_w[0]),
        .busy(busy_w[0]));
    filter_ch_scheduler #(.N(N), .NCH(NCH), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req_r[1]), .x_in(x_r), .ch_mask(mask_r),
        .ack(ack_w[1]), .flt_en(en_w[1]), .flt_x(fx_w[1]), .flt_ch(fch_w[1]),
        .flt_y(fy_w[1]), .y_out(yo_w[1]), .y_ch(ych_w[1]), .y_valid(yv_w[1]),
        .busy(busy_w[1]));
    filter_ch_scheduler #(.N(N), .NCH(NCH), .LAT(15)) dut2 (
        .clk(clk), .rst(rst), .req(req_r[2]), .x_in(x_r), .ch_mask(mask_r),
        .ack(ack_w[2]), .flt_en(en_w[2]), .flt_x(fx_w[2]), .flt_ch(fch_w[2]),
        .flt_y(fy_w[2]), .y_out(yo_w[2]), .y_ch(ych_w[2]), .y_valid(yv_w[2]),
        .busy(busy_w[2]));

    function automatic int lat_of(int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic logic [N-1:0] dp_f(logic [N-1:0] x, logic [3:0] ch);
        return (x << 4) + {12'd0, ch};
    endfunction

    // Datapath stand-in: result appears LAT cycles after the flt_en cycle, 0 otherwise.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < ND; d++)
                for (int i = 0; i < 16; i++) pipe[d][i] <= '0;
        end else begin
            for (int d = 0; d < ND; d++) begin
                pipe[d][0] <= en_w[d] ? dp_f(fx_w[d], fch_w[d]) : '0;
                for (int i = 1; i < 16; i++) pipe[d][i] <= pipe[d][i-1];
            end
        end
    end

    assign fy_w[0] = pipe[0][1];
    assign fy_w[1] = pipe[1][0];
    assign fy_w[2] = pipe[2][14];

    function automatic int rr_pick(logic [NCH-1:0] elig, int lastg);
        for (int i = 1; i <= NCH; i++)
            if (elig[(lastg + i) % NCH]) return (lastg + i) % NCH;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_idle[d] = -1000; m_ack[d] = -1000; m_en[d] = -1000; m_yv[d] = -1000;
            m_last[d] = NCH - 1;
            m_ch[d] = '0; m_pch[d] = '0; m_ych[d] = '0;
            m_x[d] = '0; m_py[d] = '0; m_yout[d] = '0;
        end
    endtask

    // A grant at edge k gives ack in cycle k, flt_en in k+1, y_valid in k+LAT+2.
    task automatic model_edge();
        int g;
        if (rst !== 1'b1) begin
            model_reset();
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (cyc == m_yv[d]) begin
                    m_yout[d] = m_py[d];
                    m_ych[d]  = m_pch[d];
                end
                if (cyc - 1 >= m_idle[d]) begin
                    g = rr_pick(req_r[d] & mask_r, m_last[d]);
                    if (g >= 0) begin
                        m_ack[d]  = cyc;
                        m_en[d]   = cyc + 1;
                        m_yv[d]   = cyc + lat_of(d) + 2;
                        m_idle[d] = cyc + lat_of(d) + 2;
                        m_ch[d]   = 4'(g);
                        m_x[d]    = x_r[g*N +: N];
                        m_py[d]   = dp_f(m_x[d], 4'(g));
                        m_pch[d]  = 4'(g);
                        m_last[d] = g;
                        if (!hold) pend[d][g] = 1'b0;
                    end
                end
            end
        end
    endtask

    function automatic logic [OW-1:0] exp_vec(int d);
        logic [NCH-1:0] a;
        a = (cyc == m_ack[d]) ? ({{(NCH-1){1'b0}}, 1'b1} << m_ch[d]) : '0;
        return {a, (cyc == m_en[d]), m_x[d], m_ch[d], m_yout[d], m_ych[d],
                (cyc == m_yv[d]), (cyc < m_idle[d])};
    endfunction

    function automatic logic [OW-1:0] obs_vec(int d);
        return {ack_w[d], en_w[d], fx_w[d], fch_w[d], yo_w[d], ych_w[d], yv_w[d], busy_w[d]};
    endfunction

    task automatic tick();
        for (int d = 0; d < ND; d++) req_r[d] = pend[d];
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        for (int d = 0; d < ND; d++) pend[d] = '0;
        hold = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        x_r = '0;
        mask_r = '1;
        for (int d = 0; d < ND; d++) pend[d] = '0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                total++;
                if (obs_vec(d) !== {OW{1'b0}}) begin
                    bad++;
                    $display("[TB] FAIL reset dut%0d got=%h want=0", d, obs_vec(d));
                end
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        int ack_at [ND];
        int en_at [ND];
        int yv_at [ND];
        logic [N-1:0] yv_val [ND];
        logic [N-1:0] en_x [ND];
        for (int d = 0; d < ND; d++) begin
            ack_at[d] = -1; en_at[d] = -1; yv_at[d] = -1; yv_val[d] = '0; en_x[d] = '0;
            pend[d] = 4'b0001;
        end
        x_r = '0;
        x_r[N-1:0] = 16'd2;
        for (int n = 0; n < 24; n++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                if (ack_w[d] != 0 && ack_at[d] < 0) ack_at[d] = cyc;
                if (en_w[d] && en_at[d] < 0) begin en_at[d] = cyc; en_x[d] = fx_w[d]; end
                if (yv_w[d] && yv_at[d] < 0) begin yv_at[d] = cyc; yv_val[d] = yo_w[d]; end
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("[TB] FAIL single dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (en_at[d] - ack_at[d] !== 1 || en_x[d] !== 16'd2) begin
                bad++;
                $display("[TB] FAIL single_en dut%0d ack@%0d en@%0d x=%0d want x=2 one cycle after ack", d, ack_at[d], en_at[d], en_x[d]);
            end
            total++;
            if (yv_at[d] - ack_at[d] !== lat_of(d) + 2 || ack_at[d] < 0) begin
                bad++;
                $display("[TB] FAIL single_lat dut%0d distance=%0d want=%0d", d, yv_at[d] - ack_at[d], lat_of(d) + 2);
            end
            total++;
            if (yv_val[d] !== 16'd32) begin
                bad++;
                $display("[TB] FAIL single_y dut%0d y_out=%0d want=32", d, yv_val[d]);
            end
        end
    endtask

    task automatic test_round_robin();
        int ackt [ND][6];
        int ackc [ND][6];
        int cnt [ND];
        do_reset();
        hold = 1'b1;
        x_r = {16'd6, 16'd5, 16'd4, 16'd3};
        for (int d = 0; d < ND; d++) begin cnt[d] = 0; pend[d] = 4'b1111; end
        for (int n = 0; n < 112; n++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                if (ack_w[d] != 0 && cnt[d] < 6) begin
                    ackt[d][cnt[d]] = cyc;
                    ackc[d][cnt[d]] = $clog2(int'(ack_w[d]));
                    cnt[d]++;
                end
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("[TB] FAIL rr dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (cnt[d] !== 6) begin
                bad++;
                $display("[TB] FAIL rr_count dut%0d acks=%0d want=6", d, cnt[d]);
            end else begin
                for (int j = 0; j < 6; j++) begin
                    total++;
                    if (ackc[d][j] !== j % NCH) begin
                        bad++;
                        $display("[TB] FAIL rr_order dut%0d grant%0d ch=%0d want=%0d", d, j, ackc[d][j], j % NCH);
                    end
                    if (j > 0) begin
                        total++;
                        if (ackt[d][j] - ackt[d][j-1] !== lat_of(d) + 3) begin
                            bad++;
                            $display("[TB] FAIL rr_spacing dut%0d gap=%0d want=%0d", d, ackt[d][j] - ackt[d][j-1], lat_of(d) + 3);
                        end
                    end
                end
            end
        end
        hold = 1'b0;
        for (int d = 0; d < ND; d++) pend[d] = '0;
        for (int n = 0; n < 20; n++) tick();
    endtask

    task automatic test_mask();
        int other [ND];
        int ch1n [ND];
        bit gap [ND];
        do_reset();
        hold = 1'b1;
        mask_r = 4'b0111;
        x_r = {$urandom, $urandom};
        for (int d = 0; d < ND; d++) begin pend[d] = 4'b1010; other[d] = 0; ch1n[d] = 0; gap[d] = 1'b0; end
        for (int n = 0; n < 60; n++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                if (ack_w[d] == 4'b0010) ch1n[d]++;
                else if (ack_w[d] != 0) other[d]++;
                if (ch1n[d] > 0 && !busy_w[d]) gap[d] = 1'b1;
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("[TB] FAIL mask dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (other[d] !== 0 || ch1n[d] < 2 || gap[d] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL mask_sum dut%0d other_acks=%0d ch1_acks=%0d idle_gap=%0d want 0,>=2,1", d, other[d], ch1n[d], gap[d]);
            end
        end
        hold = 1'b0;
        mask_r = '1;
        for (int d = 0; d < ND; d++) pend[d] = '0;
        for (int n = 0; n < 20; n++) tick();
    endtask

    task automatic test_late_request();
        int yv0 [ND];
        int ack2 [ND];
        logic [N-1:0] y0 [ND];
        logic [N-1:0] x0;
        do_reset();
        x0 = 16'($urandom);
        x_r = {$urandom, $urandom};
        x_r[N-1:0] = x0;
        for (int d = 0; d < ND; d++) begin pend[d] = 4'b0001; yv0[d] = -1; ack2[d] = -1; y0[d] = '0; end
        for (int n = 0; n < 40; n++) begin
            tick();
            if (n == 1) for (int d = 0; d < ND; d++) pend[d][2] = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (yv_w[d] && yv0[d] < 0) begin yv0[d] = cyc; y0[d] = yo_w[d]; end
                if (ack_w[d] == 4'b0100 && ack2[d] < 0) ack2[d] = cyc;
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("[TB] FAIL late dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            total++;
            if (ack2[d] !== yv0[d] + 1 || yv0[d] < 0 || y0[d] !== dp_f(x0, 4'd0)) begin
                bad++;
                $display("[TB] FAIL late_order dut%0d ch2_ack@%0d ch0_valid@%0d y=%h want ack@valid+1 y=%h", d, ack2[d], yv0[d], y0[d], dp_f(x0, 4'd0));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        x_r = {$urandom, $urandom};
        for (int d = 0; d < ND; d++) pend[d] = 4'b0010;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            total++;
            if (obs_vec(d) !== {OW{1'b0}}) begin
                bad++;
                $display("[TB] FAIL async_rst dut%0d got=%h want=0", d, obs_vec(d));
            end
        end
        model_reset();
        for (int d = 0; d < ND; d++) pend[d] = '0;
        tick();
        tick();
        rst = 1'b1;
        for (int d = 0; d < ND; d++) pend[d] = 4'b0010;
        tick();
        for (int d = 0; d < ND; d++) begin
            total++;
            if (ack_w[d] !== 4'b0010) begin
                bad++;
                $display("[TB] FAIL async_resume dut%0d ack=%b want=0010", d, ack_w[d]);
            end
        end
        for (int n = 0; n < 24; n++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("[TB] FAIL async_drain dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] r;
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            x_r = {$urandom, $urandom};
            if (n % 25 == 0) mask_r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            if ($urandom_range(0, 3) == 0) begin
                r = 4'($urandom);
                for (int d = 0; d < ND; d++) pend[d] |= r;
            end
            if ($urandom_range(0, 15) == 0) begin
                r = 4'($urandom);
                for (int d = 0; d < ND; d++) pend[d] &= r;
            end
            tick();
            for (int d = 0; d < ND; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("[TB] FAIL random dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_late_request();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
